a1csa_seq_ctrl: RTL and testbench

// Multi-cycle sequencer that computes a WIDTH-bit add on a CHUNK-bit add-one

---
 rtl/a1csa_seq_ctrl.sv | 104 ++++++++++
 tb/tb_a1csa_seq_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/a1csa_seq_ctrl.sv
// rtl/a1csa_seq_ctrl.sv - multi-cycle WIDTH-bit adder built on one CHUNK-bit add-one carry-select slice
module a1csa_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NCHK = WIDTH / CHUNK;
  localparam int KW   = (NCHK > 1) ? $clog2(NCHK) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCHK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry;

  logic [CHUNK-1:0] a_k;
  logic [CHUNK-1:0] b_k;
  logic [CHUNK:0]   s0_full;
  logic [CHUNK-1:0] s0;
  logic [CHUNK-1:0] rs;
  logic             g;
  logic             carry_nxt;

  assign a_k     = a_r[k*CHUNK +: CHUNK];
  assign b_k     = b_r[k*CHUNK +: CHUNK];
  assign s0_full = {1'b0, a_k} + {1'b0, b_k};
  assign s0      = s0_full[CHUNK-1:0];
  assign g       = s0_full[CHUNK];

  // Incoming carry flips bit i only when every lower bit of s0 is one.
  always_comb begin : add_one
    logic pre;
    pre = 1'b1;
    rs  = '0;
    for (int i = 0; i < CHUNK; i++) begin
      rs[i] = (carry & pre) ^ s0[i];
      pre   = pre & s0[i];
    end
  end

  assign carry_nxt = g | (carry & (&s0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      k     <= '0;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            carry <= cin;
            k     <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sum[k*CHUNK +: CHUNK] <= rs;
          carry                 <= carry_nxt;
          if (k == KLAST) begin
            cout  <= carry_nxt;
            k     <= '0;
            state <= S_DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_a1csa_seq_ctrl.sv
// tb/tb_a1csa_seq_ctrl.sv - self-checking bench for a1csa_seq_ctrl
module tb_a1csa_seq_ctrl;
  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int NCHK  = WIDTH / CHUNK;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        cin = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready, out_valid, cout, busy;
  logic [31:0] sum;

  a1csa_seq_ctrl #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  // Behavioural model: an accepted op yields a+b+cin exactly NCHK cycles later.
  bit          m_busy = 0;
  int          m_left = 0;
  logic [31:0] m_sum = '0;
  logic        m_cout = 1'b0;
  logic [31:0] p_sum = '0;
  logic        p_cout = 1'b0;
  bit          started = 0;
  int          done_cnt = 0;
  int          acc_q[$];

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_busy  = 0;
      m_sum   = '0;
      m_cout  = 1'b0;
      started = 1;
    end else if (!m_busy) begin
      if (in_valid) begin
        {p_cout, p_sum} = {1'b0, a} + {1'b0, b} + 33'(cin);
        m_busy = 1;
        m_left = NCHK;
        acc_q.push_back(cyc);
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_sum  = p_sum;
        m_cout = p_cout;
      end
    end else if (out_ready) begin
      m_busy = 0;
      done_cnt++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready, !m_busy);
      chk("busy", busy, m_busy);
      chk("out_valid", out_valid, m_busy && (m_left == 0));
      if (!m_busy || m_left == 0) begin
        chk("sum", sum, m_sum);
        chk("cout", cout, m_cout);
      end
    end
  end

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                       input int hold, output logic [31:0] rs, output logic rc, output int lat);
    int n;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_wait", n < 50, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'b1;
    lat = 0;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    rs = sum; rc = cout;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk("hold_sum", sum, rs);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_idle", in_ready, 1);
  endtask

  logic [31:0] rs;
  logic        rc;
  int          lat;
  int          target;
  int          guard;
  logic [31:0] ra, rb;
  logic        rcin;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_sum", sum, 32'h0);
    chk("rst_cout", cout, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", in_ready, 1);

    do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, rs, rc, lat);
    chk("ripple_sum", rs, 32'h00000000);
    chk("ripple_cout", rc, 1);
    chk("ripple_lat", lat, 4);

    do_op(32'h12345678, 32'h11111111, 1'b1, 0, rs, rc, lat);
    chk("cin_sum", rs, 32'h2345678A);
    chk("cin_cout", rc, 0);

    do_op(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 0, rs, rc, lat);
    chk("addone_sum", rs, 32'hFFFFFFFF);
    chk("addone_cout", rc, 0);

    do_op(32'h80000000, 32'h80000001, 1'b0, 6, rs, rc, lat);
    chk("bp_sum", rs, 32'h00000001);
    chk("bp_cout", rc, 1);

    // Abort on the second RUN cycle.
    @(negedge clk);
    a = 32'hDEADBEEF; b = 32'h01234567; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_sum", sum, 32'h0);
    chk("abort_cout", cout, 0);
    chk("abort_busy", busy, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_ov", out_valid, 0);
    end
    ra = $urandom; rb = $urandom; rcin = 1'b1;
    do_op(ra, rb, rcin, 0, rs, rc, lat);
    chk("post_abort", {31'b0, rc, rs}, {31'b0, {1'b0, ra} + {1'b0, rb} + 33'(rcin)});

    acc_q.delete();
    @(negedge clk);
    a = $urandom; b = $urandom; in_valid = 1'b1; out_ready = 1'b1;
    repeat (14) @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_count", acc_q.size() >= 2, 1);
    if (acc_q.size() >= 2) chk("b2b_gap", acc_q[1] - acc_q[0], NCHK + 2);

    target = done_cnt + 1000;
    guard = 0;
    while (done_cnt < target && guard < 30000) begin
      @(negedge clk);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = ~a;
        1: b = 32'hFFFFFFFF - a + 32'(($urandom_range(0, 1)));
        default: b = $urandom;
      endcase
      cin = 1'($urandom_range(0, 1));
      in_valid = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      guard++;
    end
    chk("rand_done", done_cnt >= target, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
